// File: rtl/clause_bin_loader_pkg.sv
// Shared types for the clause bin loader: literal encoding and controller state.
package clause_bin_loader_pkg;

    typedef enum logic [1:0] {
        LIT_ABSENT = 2'b00,
        LIT_POS    = 2'b01,
        LIT_NEG    = 2'b10
    } lit_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_UL_RD,
        S_UL_OUT,
        S_DONE
    } loader_state_t;

endpackage

// File: rtl/clause_bin_loader_onehot_dec.sv
// Index to one-hot decoder with enable; indices at or beyond N decode to all zeros.
module clause_bin_loader_onehot_dec #(
    parameter int N = 8,
    parameter int W = $clog2(N + 1)
) (
    input  logic         en,
    input  logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int k = 0; k < N; k++) begin
            onehot[k] = en && (idx == W'(k));
        end
    end

endmodule

// File: rtl/clause_bin_loader.sv
// Moves one clause bin between the clause streams and the clause array (load with
// zero-fill of unused slots, or unload of the first N slots).
//
// state    | meaning
// S_IDLE   | waiting for start_load_i / start_unload_i
// S_LOAD   | accepting clauses; each handshake writes its slot on the following cycle
// S_CLEAR  | flushing the last loaded clause, then zero-filling slots cnt..NUM_CLAUSES-1
// S_UL_RD  | rd_o selects slot idx for one cycle
// S_UL_OUT | captured clause presented on ul_*, held until ul_ready_i
// S_DONE   | one-cycle done_o pulse
module clause_bin_loader
    import clause_bin_loader_pkg::*;
#(
    parameter int NUM_CLAUSES = 8,
    parameter int NUM_VARS    = 8,
    parameter int WIDTH_C_LEN = 4,
    parameter int WIDTH_CNT   = $clog2(NUM_CLAUSES + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_load_i,
    input  logic                             start_unload_i,
    input  logic [WIDTH_CNT-1:0]             num_clauses_i,
    output logic                             busy_o,
    output logic                             done_o,
    input  logic                             ld_valid_i,
    output logic                             ld_ready_o,
    input  logic [NUM_VARS*2-1:0]            ld_clause_i,
    input  logic [WIDTH_C_LEN-1:0]           ld_len_i,
    output logic                             ul_valid_o,
    input  logic                             ul_ready_i,
    output logic [NUM_VARS*2-1:0]            ul_clause_o,
    output logic [WIDTH_C_LEN-1:0]           ul_len_o,
    output logic [NUM_CLAUSES-1:0]           wr_o,
    output logic [NUM_CLAUSES-1:0]           rd_o,
    output logic [NUM_VARS*2-1:0]            clause_o,
    output logic [WIDTH_C_LEN-1:0]           clause_len_o,
    input  logic [NUM_VARS*2-1:0]            clause_i,
    input  logic [WIDTH_C_LEN*NUM_CLAUSES-1:0] clause_len_i
);

    localparam int CW = NUM_VARS * 2;
    localparam logic [WIDTH_CNT-1:0] CNT_MAX     = WIDTH_CNT'(NUM_CLAUSES);
    localparam logic [CW-1:0]        ZERO_CLAUSE = {NUM_VARS{LIT_ABSENT}};

    loader_state_t state, state_next;

    logic [WIDTH_CNT-1:0]   idx, cnt, cnt_start, cnt_last;
    logic                   wr_pend;
    logic [WIDTH_CNT-1:0]   wr_idx;
    logic [CW-1:0]          wr_clause;
    logic [WIDTH_C_LEN-1:0] wr_len;
    logic                   ul_valid;
    logic [CW-1:0]          ul_clause;
    logic [WIDTH_C_LEN-1:0] ul_len;
    logic [WIDTH_C_LEN-1:0] rd_len;

    logic start_any, ld_hs, ul_hs, clear_wr;

    assign cnt_start = (num_clauses_i > CNT_MAX) ? CNT_MAX : num_clauses_i;
    assign cnt_last  = cnt - WIDTH_CNT'(1);
    assign start_any = (state == S_IDLE) && (start_load_i || start_unload_i);
    assign ld_hs     = (state == S_LOAD) && ld_valid_i;
    assign ul_hs     = (state == S_UL_OUT) && ul_ready_i;
    // A pending load write owns the array port, so zero-fill waits one cycle behind it.
    assign clear_wr  = (state == S_CLEAR) && !wr_pend && (idx != CNT_MAX);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_load_i) begin
                    state_next = (cnt_start == '0) ? S_CLEAR : S_LOAD;
                end else if (start_unload_i) begin
                    state_next = (cnt_start == '0) ? S_DONE : S_UL_RD;
                end
            end
            S_LOAD: begin
                if (ld_hs && (idx == cnt_last)) state_next = S_CLEAR;
            end
            S_CLEAR: begin
                if ((idx == CNT_MAX) || (clear_wr && (idx == CNT_MAX - WIDTH_CNT'(1)))) begin
                    state_next = S_DONE;
                end
            end
            S_UL_RD: state_next = S_UL_OUT;
            S_UL_OUT: begin
                if (ul_hs) state_next = (idx == cnt_last) ? S_DONE : S_UL_RD;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            cnt       <= '0;
            wr_pend   <= 1'b0;
            wr_idx    <= '0;
            wr_clause <= '0;
            wr_len    <= '0;
            ul_valid  <= 1'b0;
            ul_clause <= '0;
            ul_len    <= '0;
        end else begin
            wr_pend <= ld_hs;
            if (start_any) begin
                idx <= '0;
                cnt <= cnt_start;
            end else if (ld_hs || clear_wr || ul_hs) begin
                idx <= idx + WIDTH_CNT'(1);
            end
            if (ld_hs) begin
                wr_idx    <= idx;
                wr_clause <= ld_clause_i;
                wr_len    <= ld_len_i;
            end
            if (state == S_UL_RD) begin
                ul_valid  <= 1'b1;
                ul_clause <= clause_i;
                ul_len    <= rd_len;
            end else if (ul_hs) begin
                ul_valid  <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_len = '0;
        for (int k = 0; k < NUM_CLAUSES; k++) begin
            if (idx == WIDTH_CNT'(k)) rd_len = clause_len_i[k*WIDTH_C_LEN +: WIDTH_C_LEN];
        end
    end

    clause_bin_loader_onehot_dec #(.N(NUM_CLAUSES), .W(WIDTH_CNT)) u_wr_dec (
        .en     (wr_pend || clear_wr),
        .idx    (wr_pend ? wr_idx : idx),
        .onehot (wr_o)
    );

    clause_bin_loader_onehot_dec #(.N(NUM_CLAUSES), .W(WIDTH_CNT)) u_rd_dec (
        .en     (state == S_UL_RD),
        .idx    (idx),
        .onehot (rd_o)
    );

    assign clause_o     = wr_pend ? wr_clause : ZERO_CLAUSE;
    assign clause_len_o = wr_pend ? wr_len : '0;
    assign busy_o       = (state != S_IDLE);
    assign done_o       = (state == S_DONE);
    assign ld_ready_o   = (state == S_LOAD);
    assign ul_valid_o   = ul_valid;
    assign ul_clause_o  = ul_clause;
    assign ul_len_o     = ul_len;

endmodule

// File: tb/tb_clause_bin_loader.sv
// Directed bench for clause_bin_loader with a behavioural clause array behind it.
module tb_clause_bin_loader;

    localparam int NC = 8;
    localparam int CW = 16;
    localparam int LW = 4;

    localparam logic [15:0] A = 16'h1259;
    localparam logic [15:0] B = 16'h6a05;
    localparam logic [15:0] C = 16'h0240;
    localparam logic [15:0] Z = 16'h0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_load_i = 1'b0, start_unload_i = 1'b0;
    logic [3:0]    num_clauses_i = 4'd0;
    logic          busy_o, done_o;
    logic          ld_valid_i = 1'b0, ld_ready_o;
    logic [CW-1:0] ld_clause_i = '0;
    logic [LW-1:0] ld_len_i = '0;
    logic          ul_valid_o, ul_ready_i = 1'b0;
    logic [CW-1:0] ul_clause_o;
    logic [LW-1:0] ul_len_o;
    logic [NC-1:0] wr_o, rd_o;
    logic [CW-1:0] clause_o, clause_i;
    logic [LW-1:0] clause_len_o;
    logic [LW*NC-1:0] clause_len_i;

    int n_checks = 0;
    int n_fail   = 0;

    clause_bin_loader dut (
        .clk(clk), .rst(rst),
        .start_load_i(start_load_i), .start_unload_i(start_unload_i),
        .num_clauses_i(num_clauses_i), .busy_o(busy_o), .done_o(done_o),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
        .ld_clause_i(ld_clause_i), .ld_len_i(ld_len_i),
        .ul_valid_o(ul_valid_o), .ul_ready_i(ul_ready_i),
        .ul_clause_o(ul_clause_o), .ul_len_o(ul_len_o),
        .wr_o(wr_o), .rd_o(rd_o), .clause_o(clause_o), .clause_len_o(clause_len_o),
        .clause_i(clause_i), .clause_len_i(clause_len_i)
    );

    always #5 clk = ~clk;

    // Clause array model: registered writes, combinational OR-read of selected slots.
    logic [CW-1:0] mem     [NC];
    logic [LW-1:0] mem_len [NC];
    initial for (int k = 0; k < NC; k++) begin mem[k] = '0; mem_len[k] = '0; end
    always @(posedge clk)
        for (int k = 0; k < NC; k++)
            if (wr_o[k]) begin mem[k] <= clause_o; mem_len[k] <= clause_len_o; end
    always_comb begin
        clause_i = '0;
        clause_len_i = '0;
        for (int k = 0; k < NC; k++) begin
            if (rd_o[k]) clause_i = clause_i | mem[k];
            clause_len_i[k*LW +: LW] = mem_len[k];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if ((wr_o != '0 && rd_o != '0) || !$onehot0(wr_o) || !$onehot0(rd_o)) begin
                n_fail++;
                $display("FAIL strobe_exclusive: wr_o=%02h rd_o=%02h required one-hot0 and exclusive",
                         wr_o, rd_o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] dpat(input int i);
        return 16'h1000 + 16'(i) * 16'h0111;
    endfunction

    typedef struct {
        logic          sl, su;
        logic [3:0]    num;
        logic          lv;
        logic [15:0]   lc;
        logic [3:0]    ll;
        logic          ur;
        logic          busy, done, lr;
        logic [7:0]    wr;
        logic [15:0]   cl;
        logic [3:0]    cll;
        logic [7:0]    rd;
        logic          uv;
        logic [15:0]   uc;
        logic [3:0]    ul;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // inputs: sl su num lv lc ll ur | expected: busy done lr wr cl cll rd uv uc ul
        tbl.push_back('{1'b1,1'b0,4'd3,1'b0,Z,4'd0,1'b0, 1'b0,1'b0,1'b0,8'h00,Z,4'd0,8'h00,1'b0,Z,4'd0});
        tbl.push_back('{1'b0,1'b0,4'd3,1'b1,A,4'd5,1'b0, 1'b1,1'b0,1'b1,8'h00,Z,4'd0,8'h00,1'b0,Z,4'd0});
        tbl.push_back('{1'b0,1'b0,4'd3,1'b1,B,4'd3,1'b0, 1'b1,1'b0,1'b1,8'h01,A,4'd5,8'h00,1'b0,Z,4'd0});
        tbl.push_back('{1'b0,1'b0,4'd3,1'b0,Z,4'd0,1'b0, 1'b1,1'b0,1'b1,8'h02,B,4'd3,8'h00,1'b0,Z,4'd0});
        tbl.push_back('{1'b0,1'b0,4'd3,1'b1,C,4'd7,1'b0, 1'b1,1'b0,1'b1,8'h00,Z,4'd0,8'h00,1'b0,Z,4'd0});
        tbl.push_back('{1'b0,1'b0,4'd3,1'b0,Z,4'd0,1'b0, 1'b1,1'b0,1'b0,8'h04,C,4'd7,8'h00,1'b0,Z,4'd0});
        tbl.push_back('{1'b1,1'b0,4'd1,1'b0,Z,4'd0,1'b0, 1'b1,1'b0,1'b0,8'h08,Z,4'd0,8'h00,1'b0,Z,4'd0});
        tbl.push_back('{1'b0,1'b0,4'd3,1'b0,Z,4'd0,1'b0, 1'b1,1'b0,1'b0,8'h10,Z,4'd0,8'h00,1'b0,Z,4'd0});
        tbl.push_back('{1'b0,1'b0,4'd3,1'b0,Z,4'd0,1'b0, 1'b1,1'b0,1'b0,8'h20,Z,4'd0,8'h00,1'b0,Z,4'd0});
        tbl.push_back('{1'b0,1'b0,4'd3,1'b0,Z,4'd0,1'b0, 1'b1,1'b0,1'b0,8'h40,Z,4'd0,8'h00,1'b0,Z,4'd0});
        tbl.push_back('{1'b0,1'b0,4'd3,1'b0,Z,4'd0,1'b0, 1'b1,1'b0,1'b0,8'h80,Z,4'd0,8'h00,1'b0,Z,4'd0});
        tbl.push_back('{1'b0,1'b0,4'd3,1'b0,Z,4'd0,1'b0, 1'b1,1'b1,1'b0,8'h00,Z,4'd0,8'h00,1'b0,Z,4'd0});
        tbl.push_back('{1'b0,1'b1,4'd2,1'b0,Z,4'd0,1'b0, 1'b0,1'b0,1'b0,8'h00,Z,4'd0,8'h00,1'b0,Z,4'd0});
        tbl.push_back('{1'b0,1'b0,4'd2,1'b0,Z,4'd0,1'b0, 1'b1,1'b0,1'b0,8'h00,Z,4'd0,8'h01,1'b0,Z,4'd0});
        for (int r = 0; r < 4; r++)
            tbl.push_back('{1'b0,1'b0,4'd2,1'b0,Z,4'd0,1'b0, 1'b1,1'b0,1'b0,8'h00,Z,4'd0,8'h00,1'b1,A,4'd5});
        tbl.push_back('{1'b0,1'b0,4'd2,1'b0,Z,4'd0,1'b1, 1'b1,1'b0,1'b0,8'h00,Z,4'd0,8'h00,1'b1,A,4'd5});
        tbl.push_back('{1'b0,1'b0,4'd2,1'b0,Z,4'd0,1'b0, 1'b1,1'b0,1'b0,8'h00,Z,4'd0,8'h02,1'b0,Z,4'd0});
        tbl.push_back('{1'b0,1'b0,4'd2,1'b0,Z,4'd0,1'b1, 1'b1,1'b0,1'b0,8'h00,Z,4'd0,8'h00,1'b1,B,4'd3});
        tbl.push_back('{1'b0,1'b0,4'd2,1'b0,Z,4'd0,1'b0, 1'b1,1'b1,1'b0,8'h00,Z,4'd0,8'h00,1'b0,Z,4'd0});
        tbl.push_back('{1'b0,1'b0,4'd2,1'b0,Z,4'd0,1'b0, 1'b0,1'b0,1'b0,8'h00,Z,4'd0,8'h00,1'b0,Z,4'd0});

        // Reset state
        tick(); tick();
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_wr_rd", 32'({wr_o, rd_o}), 32'd0);
        check("rst_ready_valid", 32'({ld_ready_o, ul_valid_o, done_o}), 32'd0);
        rst = 1'b0;
        tick();

        // Table: load 3 (A,B,C) with a gap and an ignored start, then unload 2 with backpressure
        foreach (tbl[i]) begin
            start_load_i   = tbl[i].sl;
            start_unload_i = tbl[i].su;
            num_clauses_i  = tbl[i].num;
            ld_valid_i     = tbl[i].lv;
            ld_clause_i    = tbl[i].lc;
            ld_len_i       = tbl[i].ll;
            ul_ready_i     = tbl[i].ur;
            check($sformatf("v%0d_busy", i), 32'(busy_o), 32'(tbl[i].busy));
            check($sformatf("v%0d_done", i), 32'(done_o), 32'(tbl[i].done));
            check($sformatf("v%0d_ld_ready", i), 32'(ld_ready_o), 32'(tbl[i].lr));
            check($sformatf("v%0d_wr", i), 32'(wr_o), 32'(tbl[i].wr));
            check($sformatf("v%0d_clause", i), 32'({clause_len_o, clause_o}), 32'({tbl[i].cll, tbl[i].cl}));
            check($sformatf("v%0d_rd", i), 32'(rd_o), 32'(tbl[i].rd));
            check($sformatf("v%0d_ul_valid", i), 32'(ul_valid_o), 32'(tbl[i].uv));
            if (tbl[i].uv)
                check($sformatf("v%0d_ul_data", i), 32'({ul_len_o, ul_clause_o}), 32'({tbl[i].ul, tbl[i].uc}));
            tick();
        end
        start_load_i = 1'b0; start_unload_i = 1'b0; ld_valid_i = 1'b0; ul_ready_i = 1'b0;

        // Clamped load (12 -> 8) with valid gaps and a start pulse while busy
        begin
            logic          pend;
            int            pidx;
            num_clauses_i = 4'd12;
            start_load_i  = 1'b1;
            tick();
            start_load_i  = 1'b0;
            pend = 1'b0;
            pidx = 0;
            for (int i = 0; i < 8; i++) begin
                for (int g = 0; g < i % 3; g++) begin
                    ld_valid_i = 1'b0;
                    if (i == 4 && g == 0) begin start_load_i = 1'b1; num_clauses_i = 4'd2; end
                    else start_load_i = 1'b0;
                    check("clamp_gap_wr", 32'(wr_o), pend ? 32'(1) << pidx : 32'd0);
                    if (pend) check("clamp_gap_data", 32'({clause_len_o, clause_o}),
                                    32'({4'(pidx + 1), dpat(pidx)}));
                    pend = 1'b0;
                    tick();
                end
                start_load_i = 1'b0;
                ld_valid_i  = 1'b1;
                ld_clause_i = dpat(i);
                ld_len_i    = 4'(i + 1);
                check("clamp_ready", 32'(ld_ready_o), 32'd1);
                check("clamp_hs_wr", 32'(wr_o), pend ? 32'(1) << pidx : 32'd0);
                if (pend) check("clamp_hs_data", 32'({clause_len_o, clause_o}),
                                32'({4'(pidx + 1), dpat(pidx)}));
                pend = 1'b1;
                pidx = i;
                tick();
            end
            ld_valid_i = 1'b0;
            check("clamp_clear_wr", 32'(wr_o), 32'h80);
            check("clamp_clear_data", 32'({clause_len_o, clause_o}), 32'({4'd8, dpat(7)}));
            check("clamp_clear_ready", 32'(ld_ready_o), 32'd0);
            tick();
            check("clamp_done", 32'({done_o, busy_o}), 32'b11);
            check("clamp_done_nowr", 32'(wr_o), 32'd0);
            tick();
            check("clamp_idle", 32'({done_o, busy_o}), 32'b00);
        end

        // Reset while presenting an unloaded clause
        num_clauses_i  = 4'd1;
        start_unload_i = 1'b1;
        tick();
        start_unload_i = 1'b0;
        check("rstmid_rd", 32'(rd_o), 32'h01);
        tick();
        check("rstmid_ul", 32'({ul_valid_o, ul_len_o, ul_clause_o}), 32'({1'b1, 4'd1, dpat(0)}));
        rst = 1'b1;
        tick();
        check("rstmid_ctl", 32'({busy_o, done_o, ld_ready_o, ul_valid_o}), 32'd0);
        check("rstmid_strobes", 32'({wr_o, rd_o}), 32'd0);
        check("rstmid_data", 32'({clause_len_o, clause_o}), 32'd0);
        check("rstmid_uldata", 32'({ul_len_o, ul_clause_o}), 32'd0);
        rst = 1'b0;
        begin
            int dn = 0;
            for (int c = 0; c < 4; c++) begin
                if (done_o || busy_o) dn++;
                tick();
            end
            check("rstmid_no_done", 32'(dn), 32'd0);
        end

        // Both starts together with cnt=0: load path, eight zero writes, no reads
        begin
            int nw = 0, nr = 0, nd = 0, nbad = 0;
            num_clauses_i  = 4'd0;
            start_load_i   = 1'b1;
            start_unload_i = 1'b1;
            tick();
            start_load_i   = 1'b0;
            start_unload_i = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (wr_o != '0) begin
                    if (wr_o != 8'(1 << nw) || clause_o != '0 || clause_len_o != '0) nbad++;
                    nw++;
                end
                if (rd_o != '0) nr++;
                if (done_o) nd++;
                tick();
            end
            check("both_writes", 32'(nw), 32'd8);
            check("both_write_order", 32'(nbad), 32'd0);
            check("both_reads", 32'(nr), 32'd0);
            check("both_done", 32'(nd), 32'd1);
            check("both_idle", 32'(busy_o), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
